// File: rtl/stopwatch_lap_control.sv
// Run/pause/lap/set controller for a cascade of N_UNITS digit counters.
// Detects button edges, prescales the base tick and drives the per-unit
// up/down strobes. In SET mode it drives the strobe of the unit under the cursor.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_startstop..i_right  debounced level buttons (edge-detected internally)
//   i_carry[N_UNITS]      per-unit terminal-value flags from the counters
//   o_up/o_down[N_UNITS]  combinational per-unit increment/decrement strobes
//   o_clear               registered one-cycle clear, first IDLE cycle
//   o_hold/o_run/o_setmode  registered state decodes (LAP / RUN|LAP / SET)
//   o_cursor[CW]          unit selected in SET
//   o_overflow            combinational pulse on full-cascade wrap
module stopwatch_lap_control #(
    parameter int unsigned N_UNITS     = 4,
    parameter int unsigned TICK_DIV    = 1,
    parameter int unsigned STOP_ON_OVF = 0,
    localparam int unsigned CW         = $clog2(N_UNITS)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_startstop,
    input  logic               i_lap,
    input  logic               i_clear,
    input  logic               i_set,
    input  logic               i_up,
    input  logic               i_down,
    input  logic               i_left,
    input  logic               i_right,
    input  logic [N_UNITS-1:0] i_carry,
    output logic [N_UNITS-1:0] o_up,
    output logic [N_UNITS-1:0] o_down,
    output logic               o_clear,
    output logic               o_hold,
    output logic               o_run,
    output logic               o_setmode,
    output logic [CW-1:0]      o_cursor,
    output logic               o_overflow
);

    localparam int unsigned PCW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned NB      = 8;
    localparam bit          STOP_EN = (STOP_ON_OVF != 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_LAP   = 3'd2,
        S_PAUSE = 3'd3,
        S_SET   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [PCW-1:0]     pc_q, pc_d;
    logic [CW-1:0]      cursor_q, cursor_d;
    logic [NB-1:0]      btn_q;
    logic [NB-1:0]      btn_w;
    logic [NB-1:0]      ev;
    logic               clear_q, clear_d;
    logic               hold_q, run_q, setmode_q;
    logic               running, tick;
    logic [N_UNITS-1:0] carry_pref;

    // Event = button high while its previous sample was low
    assign btn_w = {i_right, i_left, i_down, i_up, i_set, i_clear, i_lap, i_startstop};
    assign ev    = btn_w & ~btn_q;

    assign running    = (state_q == S_RUN) || (state_q == S_LAP);
    assign tick       = running && (pc_q == PCW'(TICK_DIV - 1));
    assign o_overflow = tick && (&i_carry);

    // carry_pref[k] = AND of all lower carries (unit 0 always enabled)
    always_comb begin
        logic acc;
        acc = 1'b1;
        for (int k = 0; k < int'(N_UNITS); k++) begin
            carry_pref[k] = acc;
            acc           = acc & i_carry[k];
        end
    end

    // Strobes: cascade on tick while running, single cursor pulse in SET
    always_comb begin
        o_up   = '0;
        o_down = '0;
        if (tick) begin
            o_up = carry_pref;
        end else if (state_q == S_SET) begin
            if (ev[4] && !ev[5]) o_up   = N_UNITS'(1) << cursor_q;
            if (ev[5] && !ev[4]) o_down = N_UNITS'(1) << cursor_q;
        end
    end

    // Next state, prescaler and cursor
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cursor_d = cursor_q;
        clear_d  = 1'b0;

        if (running) begin
            pc_d = tick ? '0 : pc_q + PCW'(1);
        end

        case (state_q)
            S_IDLE: begin
                pc_d = '0;
                if (ev[0])      state_d = S_RUN;
                else if (ev[3]) state_d = S_SET;
                else if (ev[2]) clear_d = 1'b1;
            end
            S_RUN: begin
                if (ev[0])      state_d = S_PAUSE;
                else if (ev[1]) state_d = S_LAP;
            end
            S_LAP: begin
                if (ev[0])      state_d = S_PAUSE;
                else if (ev[1]) state_d = S_RUN;
            end
            S_PAUSE: begin
                if (ev[2]) begin
                    state_d = S_IDLE;
                    clear_d = 1'b1;
                    pc_d    = '0;
                end else if (ev[0]) begin
                    state_d = S_RUN;
                end else if (ev[3]) begin
                    state_d = S_SET;
                end
            end
            S_SET: begin
                if (ev[3]) state_d = S_PAUSE;
                if (ev[6] && !ev[7]) begin
                    cursor_d = (cursor_q == CW'(N_UNITS - 1)) ? '0 : cursor_q + CW'(1);
                end else if (ev[7] && !ev[6]) begin
                    cursor_d = (cursor_q == '0) ? CW'(N_UNITS - 1) : cursor_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Full-cascade wrap may stop the watch, overriding other events
        if (STOP_EN && o_overflow) state_d = S_PAUSE;
    end

    // State, prescaler, cursor, button history and registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            cursor_q  <= '0;
            btn_q     <= '0;
            clear_q   <= 1'b0;
            hold_q    <= 1'b0;
            run_q     <= 1'b0;
            setmode_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cursor_q  <= cursor_d;
            btn_q     <= btn_w;
            clear_q   <= clear_d;
            hold_q    <= (state_d == S_LAP);
            run_q     <= (state_d == S_RUN) || (state_d == S_LAP);
            setmode_q <= (state_d == S_SET);
        end
    end

    assign o_clear   = clear_q;
    assign o_hold    = hold_q;
    assign o_run     = run_q;
    assign o_setmode = setmode_q;
    assign o_cursor  = cursor_q;

endmodule

// File: tb/tb_stopwatch_lap_control.sv
// Self-checking bench for stopwatch_lap_control (N_UNITS=4, TICK_DIV=3,
// STOP_ON_OVF=1): directed scenarios followed by random button/carry traffic,
// all compared against a behavioural model of the stopwatch.
module tb_stopwatch_lap_control;

    localparam int N   = 4;
    localparam int DIV = 3;

    // Button vector bit positions used by the bench
    localparam int B_SS = 0, B_LAP = 1, B_CLR = 2, B_SET = 3;
    localparam int B_UP = 4, B_DN = 5, B_LEFT = 6, B_RIGHT = 7;

    // Model modes
    localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_PAUSE = 3, M_SET = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   btn = '0;
    logic [N-1:0] carry = '0;
    logic [N-1:0] o_up, o_down;
    logic         o_clear, o_hold, o_run, o_setmode, o_overflow;
    logic [1:0]   o_cursor;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model state
    int       m_mode;
    int       m_phase;
    int       m_cur;
    logic [7:0] m_prev;
    bit       m_clr;

    stopwatch_lap_control #(.N_UNITS(N), .TICK_DIV(DIV), .STOP_ON_OVF(1)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_startstop(btn[B_SS]),
        .i_lap      (btn[B_LAP]),
        .i_clear    (btn[B_CLR]),
        .i_set      (btn[B_SET]),
        .i_up       (btn[B_UP]),
        .i_down     (btn[B_DN]),
        .i_left     (btn[B_LEFT]),
        .i_right    (btn[B_RIGHT]),
        .i_carry    (carry),
        .o_up       (o_up),
        .o_down     (o_down),
        .o_clear    (o_clear),
        .o_hold     (o_hold),
        .o_run      (o_run),
        .o_setmode  (o_setmode),
        .o_cursor   (o_cursor),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s %s observed=%0h expected=%0h", tag, name, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_phase = 0;
        m_cur   = 0;
        m_prev  = '0;
        m_clr   = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk(tag, "o_up", 32'(o_up), 0);
        chk(tag, "o_down", 32'(o_down), 0);
        chk(tag, "o_clear", 32'(o_clear), 0);
        chk(tag, "o_hold", 32'(o_hold), 0);
        chk(tag, "o_run", 32'(o_run), 0);
        chk(tag, "o_setmode", 32'(o_setmode), 0);
        chk(tag, "o_cursor", 32'(o_cursor), 0);
        chk(tag, "o_overflow", 32'(o_overflow), 0);
    endtask

    // One clock cycle: apply inputs (just after a rising edge), check, advance model
    task automatic step(input logic [7:0] b, input logic [N-1:0] c, input string tag);
        logic [7:0]   ev;
        logic [N-1:0] e_up, e_dn;
        bit running, tick, ovf, ok;
        int nm, nph, ncur;
        bit nclr;
        btn   = b;
        carry = c;
        #1;
        ev      = b & ~m_prev;
        running = (m_mode == M_RUN) || (m_mode == M_LAP);
        tick    = running && (m_phase == DIV - 1);
        ovf     = tick && (c == '1);
        e_up    = '0;
        e_dn    = '0;
        if (tick) begin
            for (int k = 0; k < N; k++) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++) ok = ok && c[j];
                e_up[k] = ok;
            end
        end else if (m_mode == M_SET) begin
            if (ev[B_UP] && !ev[B_DN]) e_up = N'(1) << m_cur;
            if (ev[B_DN] && !ev[B_UP]) e_dn = N'(1) << m_cur;
        end

        chk(tag, "o_up", 32'(o_up), 32'(e_up));
        chk(tag, "o_down", 32'(o_down), 32'(e_dn));
        chk(tag, "o_overflow", 32'(o_overflow), 32'(ovf));
        chk(tag, "o_run", 32'(o_run), 32'(running));
        chk(tag, "o_hold", 32'(o_hold), 32'(m_mode == M_LAP));
        chk(tag, "o_setmode", 32'(o_setmode), 32'(m_mode == M_SET));
        chk(tag, "o_clear", 32'(o_clear), 32'(m_clr));
        chk(tag, "o_cursor", 32'(o_cursor), 32'(m_cur));

        nm   = m_mode;
        nph  = running ? (m_phase + 1) % DIV : m_phase;
        ncur = m_cur;
        nclr = 1'b0;
        case (m_mode)
            M_IDLE: begin
                nph = 0;
                if (ev[B_SS])       nm = M_RUN;
                else if (ev[B_SET]) nm = M_SET;
                else if (ev[B_CLR]) nclr = 1'b1;
            end
            M_RUN:   if (ev[B_SS]) nm = M_PAUSE; else if (ev[B_LAP]) nm = M_LAP;
            M_LAP:   if (ev[B_SS]) nm = M_PAUSE; else if (ev[B_LAP]) nm = M_RUN;
            M_PAUSE: begin
                if (ev[B_CLR]) begin nm = M_IDLE; nclr = 1'b1; nph = 0; end
                else if (ev[B_SS])  nm = M_RUN;
                else if (ev[B_SET]) nm = M_SET;
            end
            default: begin
                if (ev[B_SET]) nm = M_PAUSE;
                if (ev[B_LEFT] && !ev[B_RIGHT]) ncur = (m_cur + 1) % N;
                if (ev[B_RIGHT] && !ev[B_LEFT]) ncur = (m_cur + N - 1) % N;
            end
        endcase
        if (ovf) nm = M_PAUSE;

        @(posedge clk);
        #1;
        m_mode  = nm;
        m_phase = nph;
        m_cur   = ncur;
        m_clr   = nclr;
        m_prev  = b;
    endtask

    task automatic idle_n(input int n, input logic [N-1:0] c, input string tag);
        for (int i = 0; i < n; i++) step('0, c, tag);
    endtask

    initial begin
        int up0_cnt;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Start and prescale: ticks on RUN cycles 3, 6, 9
        step(8'h01, '0, "start");
        up0_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            if (o_up[0] === 1'b1 && i > 0) up0_cnt++;
            step('0, '0, "prescale");
        end
        if (o_up[0] === 1'b1) up0_cnt++;
        chk("prescale", "tick_count", 32'(up0_cnt), 3);

        // Partial cascade, then full overflow which stops the watch
        idle_n(3, 4'b0011, "cascade");
        idle_n(4, 4'b1111, "overflow");
        chk("overflow", "o_run_after", 32'(o_run), 0);

        // Lap mode: hold on, hold off, startstop out of lap
        step(8'h01, '0, "resume");
        step(8'h02, '0, "lap_on");
        idle_n(4, '0, "lap_run");
        step(8'h02, '0, "lap_off");
        idle_n(2, '0, "run");
        step(8'h02, '0, "lap_on2");
        step(8'h00, '0, "lap_run2");
        step(8'h01, '0, "lap_stop");
        idle_n(2, '0, "paused");

        // Resume preserving phase, clear ignored in RUN, clear+start in PAUSE
        step(8'h01, '0, "resume2");
        step(8'h04, '0, "clr_in_run");
        idle_n(2, '0, "run2");
        step(8'h01, '0, "pause2");
        step(8'h05, '0, "clr_ss");
        idle_n(2, '0, "idle");

        // Set mode: right wrap, up, up+down, left, exit
        step(8'h08, '0, "set_in");
        step(8'h80, '0, "right");
        step(8'h10, '0, "up");
        step(8'h00, '0, "rel");
        step(8'h30, '0, "up_dn");
        step(8'h00, '0, "rel");
        step(8'h20, '0, "down");
        step(8'h40, '0, "left");
        step(8'h00, '0, "rel");
        step(8'h80, '0, "right2");
        step(8'h08, '0, "set_out");
        idle_n(2, '0, "pause_set");
        chk("set_out", "cursor_kept", 32'(o_cursor), 3);

        // Async reset mid-run, released with startstop held high
        step(8'h01, '0, "run3");
        idle_n(4, 4'b0111, "run3");
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        btn = 8'h01;
        rst = 1'b0;
        step(8'h01, '0, "rst_held");
        idle_n(3, '0, "run4");

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            logic [7:0]   b;
            logic [N-1:0] c;
            for (int j = 0; j < 8; j++) b[j] = ($urandom_range(0, 4) == 0);
            c = ($urandom_range(0, 3) == 0) ? '1 : N'($urandom);
            step(b, c, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_lap_control.md
# stopwatch_lap_control

Parametrised run/pause/lap/set controller for a cascade of `N_UNITS` digit counters, from least-significant unit 0 to most-significant unit `N_UNITS-1`. It generalises the fixed four-unit stopwatch control with several additions:
- internal button edge detection;
- a base-tick prescaler;
- lap (display-hold) mode;
- cursor-based set mode;
- overflow handling.

It sits between the debounced button inputs and the per-unit up/down counters, which return a terminal-value carry flag.

## Interface
Parameters:
- `N_UNITS`, 4, number of cascaded counter units (≥2).
- `TICK_DIV`, 1, `i_clk` cycles per base tick of unit 0 (≥1).
- `STOP_ON_OVF`, 0, 1 = enter PAUSE on full-cascade overflow; 0 = wrap and keep running.
- `CW` (localparam), `$clog2(N_UNITS)`, cursor width.

Ports:
- `i_clk` in 1: single clock, rising edge.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_startstop`, `i_lap`, `i_clear`, `i_set` in 1 each: debounced level buttons.
- `i_up`, `i_down`, `i_left`, `i_right` in 1 each: debounced level buttons.
- `i_carry` in `N_UNITS`: bit k high while unit k holds its terminal value.
- `o_up` out `N_UNITS`: increment strobe per unit.
- `o_down` out `N_UNITS`: decrement strobe per unit.
- `o_clear` out 1: one-cycle synchronous clear of all units.
- `o_hold` out 1: display freeze (lap) request.
- `o_run` out 1: counting active (RUN or LAP).
- `o_setmode` out 1: SET state.
- `o_cursor` out `CW`: unit selected in SET.
- `o_overflow` out 1: one-cycle pulse on full-cascade wrap.

## Operation
**Edge detection**
- Each of the 8 buttons has a previous-value register; reset value 0.
- An event is input=1 while its register=0. Held levels produce no further events.
- A button held high through reset release produces one event.

**States:** IDLE, RUN, LAP, PAUSE, SET. Reset state is IDLE.

**Transitions** (evaluated per clock; events not listed for a state are ignored):
- IDLE: startstop → RUN; else set → SET; clear → stay, pulse `o_clear`.
- RUN: startstop → PAUSE; else lap → LAP.
- LAP: startstop → PAUSE (hold released); else lap → RUN (hold released).
- PAUSE: clear → IDLE + `o_clear` (priority over all other events); else startstop → RUN; else set → SET.
- SET: set → PAUSE. Up/down/left/right act as described under Set mode.

**Prescaler**
- Counter `pc` runs 0..`TICK_DIV-1`, advancing only in RUN/LAP.
- `tick` = running & (`pc==TICK_DIV-1`). `pc` wraps to 0 on tick.
- `pc` holds in PAUSE/SET and is zeroed in IDLE and on the clear transition.

**Counting** (combinational from state, `pc`, `i_carry`)
- `o_up[0]` = tick.
- `o_up[k]` = tick & (AND of `i_carry[k-1:0]`).
- `o_down` = 0 while running.

**Overflow**
- Occurs on tick with all `i_carry` bits high.
- `o_overflow` pulses in that cycle. The cascade wraps because all `o_up` bits are high.
- `STOP_ON_OVF`=1: next state PAUSE, overriding that cycle's other events.

**Set mode**
- An up event pulses `o_up[o_cursor]` for one cycle; a down event pulses `o_down[o_cursor]`.
- Simultaneous up+down events produce no pulse.
- Left: cursor+1, wrapping `N_UNITS-1` → 0. Right: cursor-1, wrapping 0 → `N_UNITS-1`. Simultaneous left+right: no move.
- The cursor is retained across SET exits and reset to 0 by `i_rst` only.
- No carry propagation in SET; the counters handle their own wrap.

**Outputs**
- `o_hold` = (state==LAP), registered.
- `o_run` = RUN|LAP.
- `o_setmode` = SET.

## Timing
- Reset values: `o_up`=0, `o_down`=0, `o_clear`=0, `o_hold`=0, `o_run`=0, `o_setmode`=0, `o_cursor`=0, `o_overflow`=0.
- `i_rst` mid-run forces IDLE immediately (asynchronously) and suppresses all strobes.
- **State change:** at the first `i_clk` edge where the event is visible. `o_run`/`o_hold`/`o_setmode` change in the cycle after that edge (one-cycle latency).
- **First tick:** on IDLE → RUN, `pc`=0, so the first `o_up[0]` appears in RUN cycle `TICK_DIV` (1-based). With `TICK_DIV`=1, ticks occur every RUN cycle, including the first.
- **Resume:** PAUSE → RUN continues from the held `pc`. Sub-tick phase is preserved.
- **Lap:** `tick` continues in LAP. RUN ↔ LAP transitions cause no tick loss or duplication.
- **Strobe timing:** `o_clear` is high exactly in the cycle after the transition edge, i.e. the first IDLE cycle. All strobes are single-cycle.
- **SET strobes:** `o_up`/`o_down` in SET are asserted in the cycle the event is detected (combinational from event and cursor).

## Test plan
- **Start/prescale:** `TICK_DIV`=3; reset, pulse `i_startstop` → `o_run`=1; `o_up[0]` pulses in RUN cycles 3, 6, 9; `o_up[3:1]`=0 while `i_carry`=0.
- **Cascade/overflow:** force `i_carry`=4'b0011 → `o_up` on tick = 4'b0111. Force `i_carry`=4'b1111 with `STOP_ON_OVF`=1 → `o_up`=4'b1111 and `o_overflow`=1 for one cycle, then state PAUSE (`o_run`=0).
- **Lap:** RUN, lap event → `o_hold`=1 with ticks uninterrupted. Lap again → `o_hold`=0. Startstop in LAP → PAUSE with `o_hold`=0.
- **Pause/clear:** in PAUSE with `pc`=1, startstop → next tick after 1 cycle (`TICK_DIV`=3). Pause again, clear+startstop same cycle → IDLE and `o_clear`=1 once; clear ignored while in RUN.
- **Set mode:** from IDLE press set → `o_setmode`=1. Right ×1 → cursor=3 (wrap). Up → `o_up`=4'b1000 one cycle. Up+down together → no strobe. Set → PAUSE with cursor still 3.
- **Async reset:** assert `i_rst` mid-RUN, between clock edges → all outputs 0 immediately. Release with `i_startstop` held high → one start event, RUN.
